// File: rtl/menshen_cfg_data_arbiter.sv
// Packet-granular 2:1 AXI-Stream arbiter (config over data, burst-limited) with in-flight tracking.
// Optional macro CFG_QUIESCE_EN: cfg grants wait in QUIESCE until the pipeline is empty.
module menshen_cfg_data_arbiter #(
    parameter int unsigned DATA_W        = 512,
    parameter int unsigned USER_W        = 128,
    parameter int unsigned MAX_CFG_BURST = 4,
    parameter int unsigned INFL_W        = 8,
    localparam int unsigned KEEP_W       = DATA_W / 8
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] s_data_tdata,
    input  logic [KEEP_W-1:0] s_data_tkeep,
    input  logic [USER_W-1:0] s_data_tuser,
    input  logic              s_data_tvalid,
    input  logic              s_data_tlast,
    output logic              s_data_tready,
    input  logic [DATA_W-1:0] s_cfg_tdata,
    input  logic [KEEP_W-1:0] s_cfg_tkeep,
    input  logic [USER_W-1:0] s_cfg_tuser,
    input  logic              s_cfg_tvalid,
    input  logic              s_cfg_tlast,
    output logic              s_cfg_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic [USER_W-1:0] m_axis_tuser,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    input  logic              pipe_pkt_done,
    output logic              grant_cfg,
    output logic [31:0]       cfg_pkt_cnt,
    output logic [31:0]       data_pkt_cnt,
    output logic [INFL_W-1:0] inflight
);

`ifdef CFG_QUIESCE_EN
    typedef enum logic [1:0] {IDLE, GRANT_DATA, GRANT_CFG, QUIESCE} state_t;
`else
    typedef enum logic [1:0] {IDLE, GRANT_DATA, GRANT_CFG} state_t;
`endif

    localparam logic [7:0] BURST_MAX = 8'(MAX_CFG_BURST);

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_rst_sync;
    logic              w_rst_n;
    logic [7:0]        r_burst;
    logic [31:0]       r_cfg_cnt;
    logic [31:0]       r_data_cnt;
    logic [INFL_W-1:0] r_inflight;
    logic              w_cfg_win;
    logic              w_last_hs;
    logic              w_cfg_last_hs;
    logic              w_data_last_hs;

    // Reset asserts asynchronously and releases on a clock edge.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) r_rst_sync <= '0;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_cfg_win      = s_cfg_tvalid && ((r_burst < BURST_MAX) || !s_data_tvalid);
    assign w_last_hs      = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    assign w_cfg_last_hs  = w_last_hs && (r_state == GRANT_CFG);
    assign w_data_last_hs = w_last_hs && (r_state == GRANT_DATA);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_cfg_win)
`ifdef CFG_QUIESCE_EN
                    w_next = QUIESCE;
`else
                    w_next = GRANT_CFG;
`endif
                else if (s_data_tvalid)
                    w_next = GRANT_DATA;
            end
            GRANT_DATA, GRANT_CFG: begin
                if (w_last_hs) w_next = IDLE;
            end
`ifdef CFG_QUIESCE_EN
            QUIESCE: begin
                if (r_inflight == '0) w_next = GRANT_CFG;
            end
`endif
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        grant_cfg     = (r_state == GRANT_CFG);
        m_axis_tdata  = grant_cfg ? s_cfg_tdata : s_data_tdata;
        m_axis_tkeep  = grant_cfg ? s_cfg_tkeep : s_data_tkeep;
        m_axis_tuser  = grant_cfg ? s_cfg_tuser : s_data_tuser;
        m_axis_tlast  = grant_cfg ? s_cfg_tlast : s_data_tlast;
        m_axis_tvalid = 1'b0;
        s_data_tready = 1'b0;
        s_cfg_tready  = 1'b0;
        if (r_state == GRANT_CFG) begin
            m_axis_tvalid = s_cfg_tvalid;
            s_cfg_tready  = m_axis_tready;
        end else if (r_state == GRANT_DATA) begin
            m_axis_tvalid = s_data_tvalid;
            s_data_tready = m_axis_tready;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= IDLE;
            r_burst    <= '0;
            r_cfg_cnt  <= '0;
            r_data_cnt <= '0;
            r_inflight <= '0;
        end else begin
            r_state <= w_next;
            if (w_cfg_last_hs) begin
                r_cfg_cnt <= r_cfg_cnt + 32'd1;
                if (r_burst < BURST_MAX) r_burst <= r_burst + 8'd1;
            end
            if (w_data_last_hs) begin
                r_data_cnt <= r_data_cnt + 32'd1;
                r_burst    <= '0;
            end
            // Simultaneous egress and ingress cancel out.
            if (w_last_hs && !pipe_pkt_done) begin
                if (r_inflight != '1) r_inflight <= r_inflight + 1'b1;
            end else if (!w_last_hs && pipe_pkt_done) begin
                if (r_inflight != '0) r_inflight <= r_inflight - 1'b1;
            end
        end
    end

    assign cfg_pkt_cnt  = r_cfg_cnt;
    assign data_pkt_cnt = r_data_cnt;
    assign inflight     = r_inflight;

endmodule

// File: tb/tb_menshen_cfg_data_arbiter.sv
// Directed bench for menshen_cfg_data_arbiter: packet-level scoreboard plus literal expectations.
module tb_menshen_cfg_data_arbiter;
    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int UW = 128;
    localparam int IW = 8;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          aresetn;
    logic [DW-1:0] s_data_tdata, s_cfg_tdata, m_axis_tdata;
    logic [KW-1:0] s_data_tkeep, s_cfg_tkeep, m_axis_tkeep;
    logic [UW-1:0] s_data_tuser, s_cfg_tuser, m_axis_tuser;
    logic          s_data_tvalid, s_data_tlast, s_data_tready;
    logic          s_cfg_tvalid, s_cfg_tlast, s_cfg_tready;
    logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic          pipe_pkt_done, grant_cfg;
    logic [31:0]   cfg_pkt_cnt, data_pkt_cnt;
    logic [IW-1:0] inflight;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned seq      = 0;
    int          rdy_mode = 0;

    beat_t       qc[$];
    beat_t       qd[$];
    bit          ord[$];
    int unsigned m_cfg, m_data, m_infl;
    bit          active, act_src;

    menshen_cfg_data_arbiter #(
        .DATA_W(DW), .USER_W(UW), .MAX_CFG_BURST(4), .INFL_W(IW)
    ) dut (
        .clk(clk), .aresetn(aresetn),
        .s_data_tdata(s_data_tdata), .s_data_tkeep(s_data_tkeep), .s_data_tuser(s_data_tuser),
        .s_data_tvalid(s_data_tvalid), .s_data_tlast(s_data_tlast), .s_data_tready(s_data_tready),
        .s_cfg_tdata(s_cfg_tdata), .s_cfg_tkeep(s_cfg_tkeep), .s_cfg_tuser(s_cfg_tuser),
        .s_cfg_tvalid(s_cfg_tvalid), .s_cfg_tlast(s_cfg_tlast), .s_cfg_tready(s_cfg_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .pipe_pkt_done(pipe_pkt_done), .grant_cfg(grant_cfg),
        .cfg_pkt_cnt(cfg_pkt_cnt), .data_pkt_cnt(data_pkt_cnt), .inflight(inflight)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = !m_axis_tready;
            default: m_axis_tready = 1'b0;
        endcase
    end

    // Scoreboard: per-source beat order, packet contiguity, counters and in-flight model.
    always @(negedge clk) begin
        beat_t e;
        bit    src, have;
        bit    last_hs;
        if (!aresetn) begin
            qc.delete(); qd.delete(); ord.delete();
            m_cfg = 0; m_data = 0; m_infl = 0; active = 0; act_src = 0;
        end else begin
            chk("cfg_pkt_cnt", DW'(cfg_pkt_cnt), DW'(m_cfg));
            chk("data_pkt_cnt", DW'(data_pkt_cnt), DW'(m_data));
            chk("inflight", DW'(inflight), DW'(m_infl));
            chk("tready_excl", DW'(s_cfg_tready & s_data_tready), '0);
            last_hs = 0;
            if (m_axis_tvalid && m_axis_tready) begin
                src = m_axis_tdata[DW-1];
                if (active) chk("no_interleave", DW'(src), DW'(act_src));
                have = src ? (qc.size() > 0) : (qd.size() > 0);
                chk("beat_expected", DW'(have), DW'(1));
                if (have) begin
                    if (src) e = qc.pop_front();
                    else     e = qd.pop_front();
                    chk("tdata", m_axis_tdata, e.d);
                    chk("tkeep", DW'(m_axis_tkeep), DW'(e.k));
                    chk("tuser", DW'(m_axis_tuser), DW'(e.u));
                    chk("tlast", DW'(m_axis_tlast), DW'(e.l));
                end
                if (m_axis_tlast) begin
                    last_hs = 1;
                    active  = 0;
                    ord.push_back(src);
                    if (src) m_cfg++;
                    else     m_data++;
                end else begin
                    active  = 1;
                    act_src = src;
                end
            end
            if (last_hs && !pipe_pkt_done) begin
                if (m_infl < 255) m_infl++;
            end else if (!last_hs && pipe_pkt_done && m_infl > 0) begin
                m_infl--;
            end
        end
    end

    task automatic drive(input bit cfg, input beat_t b, input logic v);
        if (cfg) begin
            s_cfg_tdata = b.d; s_cfg_tkeep = b.k; s_cfg_tuser = b.u; s_cfg_tlast = b.l; s_cfg_tvalid = v;
        end else begin
            s_data_tdata = b.d; s_data_tkeep = b.k; s_data_tuser = b.u; s_data_tlast = b.l; s_data_tvalid = v;
        end
    endtask

    task automatic send_pkt(input bit cfg, input int unsigned nbeats, input logic [KW-1:0] last_keep,
                            input bit done_on_last);
        beat_t bs[$];
        beat_t b;
        int    t;
        bit    rdy;
        for (int unsigned i = 0; i < nbeats; i++) begin
            for (int w = 0; w < DW / 32; w++) b.d[32*w +: 32] = $urandom;
            for (int w = 0; w < UW / 32; w++) b.u[32*w +: 32] = $urandom;
            b.d[15:0]   = 16'(seq);
            b.d[DW-1]   = cfg;
            b.l         = (i == nbeats - 1);
            b.k         = b.l ? last_keep : '1;
            seq++;
            bs.push_back(b);
            if (cfg) qc.push_back(b);
            else     qd.push_back(b);
        end
        foreach (bs[i]) begin
            drive(cfg, bs[i], 1'b1);
            t = 0;
            do begin
                @(negedge clk);
                t++;
                rdy = cfg ? s_cfg_tready : s_data_tready;
            end while (!rdy && aresetn && t < 300);
            if (!aresetn) begin
                drive(cfg, bs[i], 1'b0);
                return;
            end
            if (!rdy) begin
                chk("handshake_timeout", DW'(rdy), DW'(1));
                drive(cfg, bs[i], 1'b0);
                return;
            end
            if (done_on_last && bs[i].l) pipe_pkt_done = 1'b1;
            @(posedge clk);
            #1;
            pipe_pkt_done = 1'b0;
        end
        drive(cfg, bs[bs.size()-1], 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        aresetn = 1'b0;
        @(posedge clk); #1;
        aresetn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        pipe_pkt_done = 1'b1;
        @(posedge clk); #1;
        pipe_pkt_done = 1'b0;
    endtask

    initial begin
        bit exp_ord[7];
        exp_ord = '{1, 1, 1, 1, 0, 1, 1};
        aresetn = 1'b0; pipe_pkt_done = 1'b0; m_axis_tready = 1'b1;
        s_data_tdata = '0; s_data_tkeep = '0; s_data_tuser = '0; s_data_tvalid = 0; s_data_tlast = 0;
        s_cfg_tdata  = '0; s_cfg_tkeep  = '0; s_cfg_tuser  = '0; s_cfg_tvalid  = 0; s_cfg_tlast  = 0;

        #3;
        chk("rst_m_tvalid", DW'(m_axis_tvalid), '0);
        chk("rst_treadys", DW'({s_cfg_tready, s_data_tready}), '0);
        chk("rst_grant_cfg", DW'(grant_cfg), '0);
        chk("rst_counters", DW'({cfg_pkt_cnt, data_pkt_cnt, inflight}), '0);
        do_reset();

        // Lone 2-beat cfg packet with a partial last beat.
        send_pkt(1, 2, 64'h0000_0000_0fff_ffff, 0);
        repeat (2) @(posedge clk); #1;
        chk("cfg_only_cnt", DW'(cfg_pkt_cnt), DW'(1));
        chk("cfg_only_inflight", DW'(inflight), DW'(1));
        chk("cfg_only_data_cnt", DW'(data_pkt_cnt), '0);

        // Burst limit: 6 cfg vs 1 data, both pending from the start.
        do_reset();
        fork
            begin
                for (int i = 0; i < 6; i++) send_pkt(1, 1, '1, 0);
            end
            send_pkt(0, 2, '1, 0);
        join
        repeat (3) @(posedge clk); #1;
        chk("order_len", DW'(ord.size()), DW'(7));
        for (int i = 0; i < 7; i++)
            if (i < ord.size()) chk($sformatf("order_%0d", i), DW'(ord[i]), DW'(exp_ord[i]));

        // 3-beat data with toggling tready; cfg arrives mid-packet and must wait.
        do_reset();
        rdy_mode = 1;
        fork
            send_pkt(0, 3, 64'h0000_0000_0000_00ff, 0);
            begin
                @(posedge clk); #1;
                send_pkt(1, 1, '1, 0);
            end
        join
        rdy_mode = 0;
        repeat (3) @(posedge clk); #1;
        chk("toggle_order_len", DW'(ord.size()), DW'(2));
        if (ord.size() == 2) chk("toggle_first_src", DW'(ord[0]), '0);
        chk("toggle_data_cnt", DW'(data_pkt_cnt), DW'(1));
        chk("toggle_cfg_cnt", DW'(cfg_pkt_cnt), DW'(1));
        chk("toggle_drained", DW'(qc.size() + qd.size()), '0);

        // In-flight: coincident done and tlast, then drain and underflow.
        chk("infl_pre", DW'(inflight), DW'(2));
        send_pkt(0, 1, '1, 1);
        @(posedge clk); #1;
        chk("infl_coincident", DW'(inflight), DW'(2));
        pulse_done();
        pulse_done();
        @(posedge clk); #1;
        chk("infl_drained", DW'(inflight), '0);
        pulse_done();
        @(posedge clk); #1;
        chk("infl_underflow", DW'(inflight), '0);

        // In-flight saturation.
        do_reset();
        for (int i = 0; i < 257; i++) send_pkt(0, 1, '1, 0);
        @(posedge clk); #1;
        chk("infl_saturate", DW'(inflight), DW'(255));
        chk("sat_data_cnt", DW'(data_pkt_cnt), DW'(257));

        // Reset while a data packet is stalled mid-flight.
        rdy_mode = 2;
        repeat (2) @(posedge clk); #1;
        fork
            send_pkt(0, 3, '1, 0);
            begin
                repeat (3) @(posedge clk); #1;
                chk("stall_m_tvalid", DW'(m_axis_tvalid), DW'(1));
                aresetn = 1'b0;
                #1;
                chk("midrst_m_tvalid", DW'(m_axis_tvalid), '0);
                chk("midrst_treadys", DW'({s_cfg_tready, s_data_tready}), '0);
                chk("midrst_grant", DW'(grant_cfg), '0);
                chk("midrst_cnts", DW'({cfg_pkt_cnt, data_pkt_cnt}), '0);
                chk("midrst_inflight", DW'(inflight), '0);
            end
        join
        rdy_mode = 0;
        @(posedge clk); #1;
        aresetn = 1'b1;
        repeat (4) @(posedge clk); #1;
        send_pkt(1, 1, '1, 0);
        repeat (2) @(posedge clk); #1;
        chk("post_rst_cfg_cnt", DW'(cfg_pkt_cnt), DW'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
